// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: command-driven sequencer owning a W-stage Johnson counter register.
//   Ports: clk, rst_n (sync active-low); ena_i freezes all activity when low;
//   cmd_valid_i/cmd_ready_o handshake with cmd_op_i (STOP/RUN/STEP/LOAD), cmd_dir_i,
//   cmd_div_i (prescale) and cmd_data_i (step count or load pattern);
//   jc_q_o Johnson register, busy_o (RUN/STEP), done_o (STEP completion pulse),
//   err_o sticky illegal-pattern flag, active only when JOHNSON_ERRCHK_EN is defined.
module johnson_seq_ctrl #(
  parameter int W     = 8,
  parameter int LEN_W = 8,
  parameter int DIV_W = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [1:0]                       cmd_op_i,
  input  logic                             cmd_dir_i,
  input  logic [DIV_W-1:0]                 cmd_div_i,
  input  logic [(W>LEN_W?W:LEN_W)-1:0]     cmd_data_i,
  output logic [W-1:0]                     jc_q_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_e;
  localparam logic [1:0] OP_STOP = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_LOAD = 2'd3;
  state_e            state_q, state_d;
  logic [W-1:0]      jc_q, jc_d, shifted;
  logic              dir_q, dir_d, busy_q;
  logic [DIV_W-1:0]  div_q, div_d, pres_q, pres_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              active, tick, accept;
  assign active      = state_q == RUN || state_q == STEP;
  assign cmd_ready_o = ena_i && (state_q == IDLE || state_q == RUN);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign tick        = ena_i && active && pres_q == div_q;
  assign shifted     = dir_q ? {~jc_q[0], jc_q[W-1:1]} : {jc_q[W-2:0], ~jc_q[W-1]};
  assign jc_q_o      = jc_q;
  assign busy_o      = busy_q;
  assign done_o      = ena_i && state_q == DONE;
`ifdef JOHNSON_ERRCHK_EN
  logic err_q, err_d;
  assign err_o = err_q;
  // Legal Johnson patterns have at most one adjacent-bit transition.
  function automatic logic legal(input logic [W-1:0] p);
    logic [W-2:0] t;
    t = p[W-2:0] ^ p[W-1:1];
    return (t & (t - 1'b1)) == '0;
  endfunction
`else
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    jc_d    = jc_q;
    dir_d   = dir_q;
    div_d   = div_q;
    pres_d  = pres_q;
    rem_d   = rem_q;
`ifdef JOHNSON_ERRCHK_EN
    err_d   = err_q;
`endif
    if (ena_i) begin
      if (active) pres_d = tick ? '0 : pres_q + 1'b1;
      if (tick) jc_d = shifted;
      if (tick && state_q == STEP) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = DONE;
      end
      if (state_q == DONE) state_d = IDLE;
      // An accepted command preempts any shift due in the same cycle.
      if (accept) begin
        jc_d = jc_q;
        case (cmd_op_i)
          OP_STOP: state_d = IDLE;
          OP_RUN: begin
            dir_d   = cmd_dir_i;
            div_d   = cmd_div_i;
            pres_d  = '0;
            state_d = RUN;
          end
          OP_STEP: begin
            dir_d   = cmd_dir_i;
            div_d   = cmd_div_i;
            pres_d  = '0;
            rem_d   = cmd_data_i[LEN_W-1:0];
            state_d = cmd_data_i[LEN_W-1:0] == '0 ? DONE : STEP;
          end
          default: begin
            jc_d    = cmd_data_i[W-1:0];
            state_d = IDLE;
          end
        endcase
      end
`ifdef JOHNSON_ERRCHK_EN
      if (!legal(jc_q) || (accept && cmd_op_i == OP_LOAD && !legal(cmd_data_i[W-1:0]))) begin
        jc_d  = '0;
        err_d = 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      jc_q    <= '0;
      dir_q   <= 1'b0;
      div_q   <= '0;
      pres_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
`ifdef JOHNSON_ERRCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      jc_q    <= jc_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      pres_q  <= pres_d;
      rem_q   <= rem_d;
      busy_q  <= state_d == RUN || state_d == STEP;
`ifdef JOHNSON_ERRCHK_EN
      err_q   <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: directed scoreboard bench for johnson_seq_ctrl.
module tb_johnson_seq_ctrl;
  localparam int W = 8, LEN_W = 8, DIV_W = 4;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [DIV_W-1:0] cmd_div = '0;
  logic [7:0] cmd_data = '0;
  logic cmd_ready, busy, done, err;
  logic [7:0] jc, prev, p;
  int cyc = 0, n_vec = 0, n_bad = 0, done_cnt = 0, done_cyc = 0, n = 0;
  typedef struct {logic [7:0] pat; int cyc;} exp_t;
  exp_t q[$];

  johnson_seq_ctrl #(.W(W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_dir_i(cmd_dir), .cmd_div_i(cmd_div), .cmd_data_i(cmd_data),
    .jc_q_o(jc), .busy_o(busy), .done_o(done), .err_o(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fwd(input logic [7:0] v);
    return {v[6:0], ~v[7]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [1:0] op, input logic dir, input logic [DIV_W-1:0] dv,
                      input logic [7:0] data, output int acc);
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_div = dv; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic push(input logic [7:0] pat, input int c);
    exp_t e;
    e.pat = pat; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic mon(input int k);
    exp_t e;
    repeat (k) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_with_done", busy, 0);
      end
      if (jc !== prev) begin
        if (q.size() == 0) chk("unexpected_shift", jc, prev);
        else begin
          e = q.pop_front();
          chk("shift_pat", jc, e.pat);
          chk("shift_cyc", cyc, e.cyc);
        end
        prev = jc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1;
    step(2);
    chk("rst_jc", jc, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step(1);
    // STEP fwd 3, div 0
    prev = jc; done_cnt = 0;
    send(2'd2, 1'b0, 0, 8'd3, n);
    chk("step3_acc_jc", jc, 0); chk("step3_busy", busy, 1); chk("step3_ready", cmd_ready, 0);
    push(8'h01, n + 1); push(8'h03, n + 2); push(8'h07, n + 3);
    mon(5);
    chk("step3_left", q.size(), 0); chk("step3_done_cnt", done_cnt, 1);
    chk("step3_done_cyc", done_cyc, n + 3); chk("step3_ready_back", cmd_ready, 1);
    // LOAD 0 then STEP rev 1
    send(2'd3, 1'b0, 0, 8'h00, n);
    chk("load0_jc", jc, 0);
    prev = jc; done_cnt = 0;
    send(2'd2, 1'b1, 0, 8'd1, n);
    push(8'h80, n + 1);
    mon(3);
    chk("rev1_left", q.size(), 0); chk("rev1_done_cnt", done_cnt, 1);
    // RUN fwd div 2, wrap after 16 shifts, then STOP
    send(2'd3, 1'b0, 0, 8'h00, n);
    prev = jc;
    send(2'd1, 1'b0, 4'd2, 8'h00, n);
    chk("run_busy", busy, 1);
    p = 8'h00;
    for (int i = 1; i <= 16; i++) begin p = fwd(p); push(p, n + 3 * i); end
    mon(48);
    chk("run_left", q.size(), 0); chk("run_wrap_jc", jc, 0);
    send(2'd0, 1'b0, 0, 8'h00, n);
    prev = jc;
    mon(6);
    chk("stop_jc", jc, 0); chk("stop_busy", busy, 0);
    // STEP count 0
    prev = jc;
    send(2'd2, 1'b0, 0, 8'd0, n);
    chk("step0_done", done, 1); chk("step0_busy", busy, 0);
    chk("step0_ready", cmd_ready, 0); chk("step0_jc", jc, prev);
    step(1);
    chk("step0_done_clr", done, 0); chk("step0_ready_back", cmd_ready, 1);
    // STEP 4 div 1 with a LOAD held pending until IDLE
    prev = jc; done_cnt = 0;
    send(2'd2, 1'b0, 4'd1, 8'd4, n);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = 8'hF0;
    push(8'h01, n + 2); push(8'h03, n + 4); push(8'h07, n + 6); push(8'h0F, n + 8);
    mon(8);
    chk("hold_left", q.size(), 0); chk("hold_done_cnt", done_cnt, 1);
    chk("hold_ready_done", cmd_ready, 0); chk("hold_jc_done", jc, 8'h0F);
    step(1);
    chk("hold_ready_idle", cmd_ready, 1); chk("hold_jc_idle", jc, 8'h0F);
    step(1);
    cmd_valid = 1'b0;
    chk("hold_load_jc", jc, 8'hF0);
    // ena low mid-STEP: state, prescaler and remaining hold
    send(2'd3, 1'b0, 0, 8'h00, n);
    prev = jc; done_cnt = 0;
    send(2'd2, 1'b0, 0, 8'd3, n);
    push(8'h01, n + 1); push(8'h03, n + 7); push(8'h07, n + 8);
    mon(1);
    ena = 1'b0;
    mon(5);
    chk("ena_hold_jc", jc, 8'h01); chk("ena_hold_ready", cmd_ready, 0); chk("ena_hold_busy", busy, 1);
    ena = 1'b1;
    mon(4);
    chk("ena_left", q.size(), 0); chk("ena_done_cnt", done_cnt, 1); chk("ena_done_cyc", done_cyc, n + 8);
    // reset mid-STEP with ena low window and a simultaneous command
    send(2'd2, 1'b0, 0, 8'd10, n);
    step(2);
    chk("midstep_jc", jc, 8'h1F);
    ena = 1'b0;
    step(5);
    chk("midstep_hold_jc", jc, 8'h1F); chk("midstep_hold_busy", busy, 1); chk("midstep_hold_done", done, 0);
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1;
    step(1);
    chk("rst2_jc", jc, 0); chk("rst2_busy", busy, 0); chk("rst2_done", done, 0);
    chk("rst2_err", err, 0); chk("rst2_ready", cmd_ready, 1);
    rst_n = 1'b1; cmd_valid = 1'b0;
    step(1);
    chk("rst2_after_busy", busy, 0); chk("rst2_after_jc", jc, 0);
    // LOAD illegal pattern 01010000
    send(2'd3, 1'b0, 0, 8'h50, n);
`ifdef JOHNSON_ERRCHK_EN
    chk("illegal_err", err, 1); chk("illegal_jc", jc, 0);
    p = fwd(8'h00);
`else
    chk("illegal_err", err, 0); chk("illegal_jc", jc, 8'h50);
    p = fwd(8'h50);
`endif
    prev = jc; done_cnt = 0;
    send(2'd2, 1'b0, 0, 8'd1, n);
    push(p, n + 1);
    mon(3);
    chk("illegal_step_left", q.size(), 0); chk("illegal_step_done", done_cnt, 1);
`ifdef JOHNSON_ERRCHK_EN
    chk("illegal_err_sticky", err, 1);
`else
    chk("illegal_err_sticky", err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
